// File: rtl/hamming_bit_counter.sv
// hamming_bit_counter: streams two 1024-bit hashes as 64-bit word pairs and
// publishes their Hamming distance (XOR, one popcount pipeline stage, then an
// accumulator) as a zero-extended 64-bit count with a one-cycle done pulse.
module hamming_bit_counter #(
   parameter int WORDS  = 16,
   parameter int WORD_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [WORD_W-1:0] hash_word_i,
   input  logic [WORD_W-1:0] target_word_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [63:0]       bit_count_o
);
   localparam int ACC_W = $clog2(WORDS * WORD_W + 1);
   localparam int PC_W  = $clog2(WORD_W + 1);
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               pc_valid_q, pc_valid_d;
   logic [63:0]        bit_count_q, bit_count_d;
   logic               done_q, done_d;
   logic [ACC_W-1:0]   total;

   function automatic logic [PC_W-1:0] popcount(input logic [WORD_W-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < WORD_W; i++) c = c + PC_W'(v[i]);
      return c;
   endfunction

   // ready/busy decode only from the registered state, so no input reaches them
   assign word_ready_o = (state_q == ACCUM);
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign bit_count_o  = bit_count_q;

   // the final total folds in the last word's popcount still sitting in pc_q
   assign total = acc_q + ACC_W'(pc_q);

   // next-state logic: FSM plus popcount stage and accumulator updates
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = pc_valid_q ? total : acc_q;
      pc_d        = pc_q;
      pc_valid_d  = 1'b0;
      bit_count_d = bit_count_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            idx_d   = '0;
         end
         ACCUM: if (word_valid_i) begin
            pc_d       = popcount(hash_word_i ^ target_word_i);
            pc_valid_d = 1'b1;
            idx_d      = idx_q + 1'b1;
            state_d    = (idx_q == IDX_W'(WORDS - 1)) ? DRAIN : ACCUM;
         end
         DRAIN: begin
            bit_count_d = 64'(total);
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers; asynchronous reset discards any frame in flight
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         pc_q        <= '0;
         pc_valid_q  <= 1'b0;
         bit_count_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         pc_q        <= pc_d;
         pc_valid_q  <= pc_valid_d;
         bit_count_q <= bit_count_d;
         done_q      <= done_d;
      end
   end
endmodule

// File: tb/tb_hamming_bit_counter.sv
// tb_hamming_bit_counter: table-driven frames with a scoreboard of expected counts
module tb_hamming_bit_counter;
   localparam int WORDS  = 16;
   localparam int WORD_W = 64;

   typedef logic [WORDS-1:0][WORD_W-1:0] frame_t;
   typedef struct {
      frame_t      h;
      frame_t      t;
      bit          bub;
      bit          noise;
      logic [63:0] exp;
   } vec_t;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              start_i = 1'b0;
   logic [WORD_W-1:0] hash_word_i = '0;
   logic [WORD_W-1:0] target_word_i = '0;
   logic              word_valid_i = 1'b0;
   logic              word_ready_o;
   logic              busy_o;
   logic              done_o;
   logic [63:0]       bit_count_o;

   hamming_bit_counter #(.WORDS(WORDS), .WORD_W(WORD_W)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start_i),
      .hash_word_i  (hash_word_i),
      .target_word_i(target_word_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .bit_count_o  (bit_count_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_res = '0;
   bit          hold_start = 1'b0;
   vec_t        v[5];
   frame_t      fh, ft;
   logic [63:0] e;
   time         t_prev;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // called at a negedge in IDLE; leaves the bench at the negedge while in DRAIN
   task automatic run_frame(input frame_t h, input frame_t t, input bit bub, input bit noise,
                            input logic [63:0] exp);
      start_i = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk_i);
      start_i = hold_start | noise;
      for (int k = 0; k < WORDS; k++) begin
         if (bub)
            for (int b = 0; b < 3 && $urandom_range(0, 2) == 0; b++) begin
               word_valid_i  = 1'b0;
               hash_word_i   = {$urandom, $urandom};
               target_word_i = {$urandom, $urandom};
               @(negedge clk_i);
            end
         chk("accum_ready", word_ready_o, 1);
         chk("accum_busy", busy_o, 1);
         chk("accum_no_done", done_o, 0);
         chk("accum_hold", bit_count_o, last_res);
         word_valid_i  = 1'b1;
         hash_word_i   = h[k];
         target_word_i = t[k];
         @(negedge clk_i);
      end
      word_valid_i = 1'b0;
      hash_word_i  = '1;
      chk("drain_ready", word_ready_o, 0);
      chk("drain_busy", busy_o, 1);
      chk("drain_no_done", done_o, 0);
      chk("drain_hold", bit_count_o, last_res);
   endtask

   task automatic wait_done(input bit full);
      int n = 0;
      do begin
         @(negedge clk_i);
         start_i = hold_start;
         n++;
      end while (!done_o && n < 60);
      chk("done_seen", done_o, 1);
      if (full) chk("latency", n, 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("bit_count", bit_count_o, e);
         last_res = e;
      end else chk("scoreboard_size", exp_q.size(), 1);
      chk("done_ready", word_ready_o, 0);
      chk("done_busy", busy_o, 0);
   endtask

   initial begin
      for (int k = 0; k < WORDS; k++) begin
         v[0].h[k] = 64'hDEADBEEF_CAFEF00D;
         v[0].t[k] = 64'hDEADBEEF_CAFEF00D;
         v[1].h[k] = '1;
         v[1].t[k] = '0;
         v[2].t[k] = {$urandom, $urandom};
         v[2].h[k] = v[2].t[k] ^ (64'd1 << k);
         v[3].t[k] = {$urandom, $urandom};
         v[3].h[k] = v[3].t[k];
         v[4].t[k] = {$urandom, $urandom};
         v[4].h[k] = v[4].t[k];
      end
      v[3].h[0] ^= 64'hFFFF_FFFF;
      v[3].h[5] ^= 64'h1F << 10;
      v[4].h[15] ^= 64'h8000_0000_0000_0001;
      v[4].h[7] ^= 64'h7 << 30;
      v[0].bub = 0; v[0].noise = 0; v[0].exp = 64'd0;
      v[1].bub = 0; v[1].noise = 0; v[1].exp = 64'd1024;
      v[2].bub = 1; v[2].noise = 0; v[2].exp = 64'd16;
      v[3].bub = 0; v[3].noise = 1; v[3].exp = 64'd37;
      v[4].bub = 0; v[4].noise = 0; v[4].exp = 64'd5;

      repeat (2) @(negedge clk_i);
      chk("rst_count", bit_count_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ready", word_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // frames run back to back: each start is raised in the previous done cycle
      for (int i = 0; i < 5; i++) begin
         run_frame(v[i].h, v[i].t, v[i].bub, v[i].noise, v[i].exp);
         wait_done(!v[i].bub);
      end

      // abort a frame after 9 accepted words with an asynchronous reset
      start_i = 1'b1;
      exp_q.push_back(64'd999);
      @(negedge clk_i);
      start_i = 1'b0;
      for (int k = 0; k < 9; k++) begin
         word_valid_i  = 1'b1;
         hash_word_i   = '1;
         target_word_i = '0;
         @(negedge clk_i);
      end
      #2 rst_n_i = 1'b0;
      #1;
      chk("midrst_count", bit_count_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_ready", word_ready_o, 0);
      chk("midrst_busy", busy_o, 0);
      exp_q.delete();
      last_res = '0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         word_valid_i = k[0];
         chk("postrst_no_done", done_o, 0);
         chk("postrst_idle", busy_o, 0);
      end
      word_valid_i = 1'b0;
      for (int k = 0; k < WORDS; k++) begin
         ft[k] = {$urandom, $urandom};
         fh[k] = ft[k];
      end
      fh[0] = ~ft[0];
      fh[1] = ft[1] ^ 64'hF_FFFF_FFFF;
      run_frame(fh, ft, 0, 0, 64'd100);
      wait_done(1);

      // start held high: a new frame every WORDS+2 cycles
      hold_start = 1'b1;
      t_prev = $time;
      for (int f = 0; f < 3; f++) begin
         e = '0;
         for (int k = 0; k < WORDS; k++) begin
            ft[k] = {$urandom, $urandom};
            fh[k] = {$urandom, $urandom};
            e += 64'($countones(fh[k] ^ ft[k]));
         end
         run_frame(fh, ft, 0, 0, e);
         wait_done(1);
         if (f > 0) chk("period", 64'(($time - t_prev) / 10), WORDS + 2);
         t_prev = $time;
      end
      hold_start = 1'b0;
      start_i = 1'b0;
      @(negedge clk_i);
      chk("pulse_width", done_o, 0);
      chk("final_idle", busy_o, 0);
      chk("final_hold", bit_count_o, last_res);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
